fan_tree_pipe: RTL and testbench
================================

// Module: fan_tree_pipe
// PURPOSE
//  Parametrised, pipelined successor to the fixed 8-leaf FAN reduction tree.
//  Reduces N multiplier products per beat into variable-size contiguous segments; each segment's
//  sum appears at its last lane. Registered per level, valid/ready flow control at both ends.
//  Open segments carry across beats, so clusters larger than N or spanning beats reduce correctly.
//  Sits between the multiplier array and the output accumulator buffer.
// PARAMETERS
//  N         8                 leaves per beat; power of 2, >=2
//  DW_DATA   8                 signed input element width
//  DW_OUT    16                signed output/carry width; >= DW_DATA+$clog2(N)
//  N_LEVELS  $clog2(N)         derived, do not override
// PORTS
//  clk            in   1           clock
//  rst_n          in   1           asynchronous active-low reset
//  in_valid       in   1           input beat valid
//  in_ready       out  1           input beat accepted when in_valid&&in_ready
//  in_data        in   N*DW_DATA   lane i at [i*DW_DATA +: DW_DATA], two's complement
//  in_last        in   N           bit i=1: lane i closes a segment
//  in_sop         in   1           discard pending carry before this beat
//  out_valid      out  1           output beat valid
//  out_ready      in   1           output beat consumed when out_valid&&out_ready
//  out_data       out  N*DW_OUT    lane i at [i*DW_OUT +: DW_OUT]
//  out_mask       out  N           lanes holding a segment result (= in_last of the beat)
//  carry_pending  out  1           an open segment's partial sum is held
// BEHAVIOUR
//  - Reset (async, rst_n=0): every pipeline valid bit, out_valid, out_data, out_mask,
//    carry register and carry_pending cleared to 0 immediately. In-flight beats are dropped.
//    After release the first output comes only from a beat accepted after release.
//  - Flow control: en = !out_valid || out_ready; all stages advance together when en=1.
//    in_ready = en (combinational). Bubbles carry valid=0. One beat/cycle when unstalled.
//  - Latency: N_LEVELS+1 cycles from acceptance to out_valid: N_LEVELS adder levels,
//    then one output/carry stage. Beats leave in acceptance order.
//  - Lane sums: segment = lanes after the previous set in_last bit (or lane 0) up to and
//    including lane i where in_last[i]=1. Inputs are sign-extended to DW_OUT. All adds
//    are modulo 2^DW_OUT (wrap, no saturation).
//  - out_data lane i = segment sum if in_last[i], else 0. out_mask = in_last of the beat.
//  - Carry (output stage, in beat order): C = (carry_pending && !in_sop) ? carry : 0.
//    C is added to the first segment of the beat.
//    * in_last==0:                 out_mask=0; carry <= C + beat sum; carry_pending <= 1.
//    * in_last!=0, in_last[N-1]=0: carry <= sum of lanes after highest set bit; pending <= 1.
//    * in_last[N-1]=1:             carry <= 0; carry_pending <= 0.
//  - Carry and out regs update only when the final stage fires (en=1 and holding a valid beat).
//  - in_sop with nothing pending: no effect. in_sop and in_last==0: carry starts from beat sum.
//  - Stall: out_data, out_mask and out_valid hold stable while out_valid && !out_ready.
//  - Config bits (in_last, in_sop) travel with their beat through every stage.
//  - Control state: per-stage valid shift, no FSM.
// TESTING
//  1 N=8, in_last=8'hFF, data lane i=i+1, sop=1 -> 4 cycles later out_data lanes 1..8,
//    mask FF, carry_pending 0.
//  2 in_last=8'h88, all lanes=3 -> lanes 3 and 7 =12, others 0, mask 88, pending 0.
//  3 Carry chain:
//    - B1: sop=1, last=08, all 1 -> lane3=4, pending=1 (carry 4).
//    - B2: last=01, all 2 -> lane0=6, carry=14.
//    - B3: sop=1, last=80, all 1 -> lane7=8, pending 0.
//  4 Backpressure: stream 8 beats, out_ready=0 for 6 cycles -> in_ready drops once
//    N_LEVELS+2 beats held; all 8 outputs later in order, no loss or duplication,
//    outputs stable while stalled.
//  5 Signed: all lanes 8'h80, last=80 -> lane7=16'hFC00; all 8'h7F, last=80 -> 16'h03F8.
//  6 Reset with 3 beats in flight and pending carry -> out_valid=0, carry_pending=0 at once.
//    A beat after release (last=01, lane0=5, no sop) -> lane0=5, no stale carry.

Source files
------------

// File: rtl/fan_tree_pipe.sv
// Segmented reduction tree: sums contiguous lane segments per beat, with open segments carried across beats.
// Latency: N_LEVELS+2 register stages (accept edge + N_LEVELS+1 cycles to out_valid).
// Backpressure: every stage advances only when the output register is free or being consumed; in_ready = that enable.
module fan_tree_pipe #(
    parameter int N        = 8,
    parameter int DW_DATA  = 8,
    parameter int DW_OUT   = 16,
    parameter int N_LEVELS = $clog2(N)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N*DW_DATA-1:0]  in_data,
    input  logic [N-1:0]          in_last,
    input  logic                  in_sop,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [N*DW_OUT-1:0]   out_data,
    output logic [N-1:0]          out_mask,
    output logic                  carry_pending
);

    localparam int L = N_LEVELS;

    typedef logic [N-1:0][DW_OUT-1:0] lanes_t;

    // Stage k holds the segmented scan after k doubling steps; stage 0 is the sign-extended input.
    lanes_t       val_q   [0:L];
    lanes_t       val_d   [0:L];
    logic [N-1:0] start_q [0:L];
    logic [N-1:0] start_d [0:L];
    logic [N-1:0] last_q  [0:L];
    logic [L:0]   sop_q;
    logic [L:0]   vld_q;

    // Output / carry stage state
    logic         out_valid_q;
    lanes_t       out_data_q;
    logic [N-1:0] out_mask_q;
    logic [DW_OUT-1:0] carry_q;
    logic         pend_q;

    lanes_t            out_d;
    logic [DW_OUT-1:0] carry_d;
    logic              pend_d;
    logic [DW_OUT-1:0] c_in;
    logic              en;

    assign en            = !out_valid_q || out_ready;
    assign in_ready      = en;
    assign out_valid     = out_valid_q;
    assign out_data      = out_data_q;
    assign out_mask      = out_mask_q;
    assign carry_pending = pend_q;

    // Segmented inclusive scan: a lane flagged as a segment start stops absorbing lanes to its left.
    always_comb begin
        int j;
        j = 0;
        for (int i = 0; i < N; i++) begin
            val_d[0][i] = {{(DW_OUT-DW_DATA){in_data[i*DW_DATA+DW_DATA-1]}},
                           in_data[i*DW_DATA +: DW_DATA]};
        end
        // A segment starts at lane 0 and right after every closing lane.
        start_d[0] = {in_last[N-2:0], 1'b1};
        for (int k = 0; k < L; k++) begin
            for (int i = 0; i < N; i++) begin
                j = (i >= (1 << k)) ? i - (1 << k) : 0;
                val_d[k+1][i]   = val_q[k][i];
                start_d[k+1][i] = start_q[k][i];
                if (i >= (1 << k) && !start_q[k][i]) begin
                    val_d[k+1][i]   = val_q[k][j] + val_q[k][i];
                    start_d[k+1][i] = start_q[k][j];
                end
            end
        end
    end

    // Pipeline registers; the whole tree moves in lock-step with the output stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            sop_q <= '0;
            for (int k = 0; k <= L; k++) begin
                val_q[k]   <= '0;
                start_q[k] <= '0;
                last_q[k]  <= '0;
            end
        end else if (en) begin
            vld_q <= {vld_q[L-1:0], in_valid};
            sop_q <= {sop_q[L-1:0], in_sop};
            last_q[0] <= in_last;
            for (int k = 0; k <= L; k++) begin
                val_q[k]   <= val_d[k];
                start_q[k] <= start_d[k];
            end
            for (int k = 1; k <= L; k++) begin
                last_q[k] <= last_q[k-1];
            end
        end
    end

    // Fold the carried partial sum into the first segment and compute the next carry.
    always_comb begin
        logic seen;
        seen = 1'b0;
        c_in = (pend_q && !sop_q[L]) ? carry_q : '0;
        for (int i = 0; i < N; i++) begin
            out_d[i] = '0;
            if (last_q[L][i]) begin
                if (!seen) out_d[i] = val_q[L][i] + c_in;
                else       out_d[i] = val_q[L][i];
                seen = 1'b1;
            end
        end
        // Lane N-1 of the scan holds the open tail (or whole beat when nothing closed).
        if (last_q[L] == '0)          carry_d = c_in + val_q[L][N-1];
        else if (!last_q[L][N-1])     carry_d = val_q[L][N-1];
        else                          carry_d = '0;
        pend_d = !last_q[L][N-1];
    end

    // Output and carry registers change only when a valid beat leaves the tree.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_mask_q  <= '0;
            carry_q     <= '0;
            pend_q      <= 1'b0;
        end else if (en) begin
            out_valid_q <= vld_q[L];
            if (vld_q[L]) begin
                out_data_q <= out_d;
                out_mask_q <= last_q[L];
                carry_q    <= carry_d;
                pend_q     <= pend_d;
            end
        end
    end

endmodule

// File: tb/tb_fan_tree_pipe.sv
// Bench for fan_tree_pipe: directed beats plus random traffic against a running-sum scoreboard.
// Latency measured from acceptance; outputs checked in acceptance order.
// Random out_ready stalls exercise hold/stability of the output register.
module tb_fan_tree_pipe;

    localparam int N   = 8;
    localparam int DW  = 8;
    localparam int DWO = 16;
    localparam int L   = $clog2(N);

    logic                clk = 1'b0;
    logic                rst_n;
    logic                in_valid;
    logic                in_ready;
    logic [N*DW-1:0]     in_data;
    logic [N-1:0]        in_last;
    logic                in_sop;
    logic                out_valid;
    logic                out_ready;
    logic [N*DWO-1:0]    out_data;
    logic [N-1:0]        out_mask;
    logic                carry_pending;

    always #5 clk = ~clk;

    fan_tree_pipe #(.N(N), .DW_DATA(DW), .DW_OUT(DWO)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .in_last       (in_last),
        .in_sop        (in_sop),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_mask      (out_mask),
        .carry_pending (carry_pending)
    );

    typedef struct {
        logic [N*DWO-1:0] data;
        logic [N-1:0]     mask;
        logic             pend;
        logic             has_hand;
        logic [N*DWO-1:0] hdata;
    } exp_t;

    exp_t             exp_q[$];
    int               checks   = 0;
    int               failures = 0;
    logic             m_pend   = 1'b0;
    logic [DWO-1:0]   m_carry  = '0;
    logic             h_arm    = 1'b0;
    logic [N*DWO-1:0] h_data   = '0;
    logic             stall_prev = 1'b0;
    logic [N*DWO-1:0] sv_data;
    logic [N-1:0]     sv_mask;
    logic             out_seen = 1'b0;

    task automatic check_eq(input string tag, input logic [N*DWO-1:0] obs, input logic [N*DWO-1:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Reference: walk the lanes with a running sum; a closing lane emits and restarts it.
    task automatic model_push(input logic [N*DW-1:0] d, input logic [N-1:0] l, input logic s);
        exp_t e;
        logic [DWO-1:0] acc;
        logic [DW-1:0]  x;
        acc    = (m_pend && !s) ? m_carry : '0;
        e.data = '0;
        for (int i = 0; i < N; i++) begin
            x   = d[i*DW +: DW];
            acc = acc + {{(DWO-DW){x[DW-1]}}, x};
            if (l[i]) begin
                e.data[i*DWO +: DWO] = acc;
                acc = '0;
            end
        end
        m_carry    = acc;
        m_pend     = !l[N-1];
        e.mask     = l;
        e.pend     = m_pend;
        e.has_hand = h_arm;
        e.hdata    = h_data;
        h_arm      = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic step(input logic iv, input logic [N*DW-1:0] d, input logic [N-1:0] l,
                        input logic s, input logic ordy, output logic acc);
        exp_t e;
        @(negedge clk);
        in_valid  = iv;
        in_data   = d;
        in_last   = l;
        in_sop    = s;
        out_ready = ordy;
        #1;
        if (stall_prev) begin
            check_eq("stall_valid", out_valid, 1);
            check_eq("stall_data", out_data, sv_data);
            check_eq("stall_mask", out_mask, sv_mask);
        end
        if (out_valid && out_ready) begin
            out_seen = 1'b1;
            if (exp_q.size() == 0) begin
                check_eq("spurious_out", out_valid, 0);
            end else begin
                e = exp_q.pop_front();
                check_eq("out_data", out_data, e.data);
                check_eq("out_mask", out_mask, e.mask);
                check_eq("carry_pending", carry_pending, e.pend);
                if (e.has_hand) check_eq("directed_data", out_data, e.hdata);
            end
        end
        stall_prev = out_valid && !out_ready;
        sv_data    = out_data;
        sv_mask    = out_mask;
        acc        = iv && in_ready;
        if (acc) model_push(d, l, s);
    endtask

    task automatic send(input logic [N*DW-1:0] d, input logic [N-1:0] l, input logic s);
        logic acc;
        acc = 1'b0;
        for (int t = 0; t < 50 && !acc; t++) step(1'b1, d, l, s, 1'b1, acc);
        if (!acc) check_eq("send_timeout", acc, 1);
    endtask

    task automatic drain();
        logic a;
        for (int t = 0; t < 100 && exp_q.size() != 0; t++) step(1'b0, '0, '0, 1'b0, 1'b1, a);
        check_eq("drain_empty", exp_q.size(), 0);
    endtask

    task automatic rand_beat(output logic [N*DW-1:0] d, output logic [N-1:0] l, output logic s);
        for (int i = 0; i < N; i++) d[i*DW +: DW] = DW'($urandom);
        case ($urandom_range(0, 3))
            0:       l = '0;
            1:       l = N'($urandom) | {1'b1, {(N-1){1'b0}}};
            default: l = N'($urandom);
        endcase
        s = ($urandom_range(0, 5) == 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N*DW-1:0]  d;
        logic [N*DWO-1:0] hd;
        logic [N-1:0]     l;
        logic             s, iv, acc;
        int               n, cnt;

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = '0; in_sop = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_carry_pending", carry_pending, 0);
        check_eq("rst_out_data", out_data, 0);
        check_eq("rst_out_mask", out_mask, 0);
        rst_n = 1'b1;
        #1;
        check_eq("rst_in_ready", in_ready, 1);

        // Full-close beat, lanes 1..8; latency counted in edges after the accept edge.
        for (int i = 0; i < N; i++) begin
            d[i*DW +: DW]    = DW'(i + 1);
            hd[i*DWO +: DWO] = DWO'(i + 1);
        end
        h_arm = 1'b1; h_data = hd;
        send(d, 8'hFF, 1'b1);
        out_seen = 1'b0; n = 0;
        while (!out_seen && n < 20) begin
            step(1'b0, '0, '0, 1'b0, 1'b1, acc);
            n++;
        end
        check_eq("latency", n - 1, L + 1);
        drain();

        // Two segments of four lanes, all 3.
        for (int i = 0; i < N; i++) d[i*DW +: DW] = 8'd3;
        hd = '0; hd[3*DWO +: DWO] = 16'd12; hd[7*DWO +: DWO] = 16'd12;
        h_arm = 1'b1; h_data = hd;
        send(d, 8'h88, 1'b0);
        drain();

        // Carry chain across beats.
        for (int i = 0; i < N; i++) d[i*DW +: DW] = 8'd1;
        hd = '0; hd[3*DWO +: DWO] = 16'd4;
        h_arm = 1'b1; h_data = hd;
        send(d, 8'h08, 1'b1);
        for (int i = 0; i < N; i++) d[i*DW +: DW] = 8'd2;
        hd = '0; hd[0 +: DWO] = 16'd6;
        h_arm = 1'b1; h_data = hd;
        send(d, 8'h01, 1'b0);
        for (int i = 0; i < N; i++) d[i*DW +: DW] = 8'd1;
        hd = '0; hd[7*DWO +: DWO] = 16'd8;
        h_arm = 1'b1; h_data = hd;
        send(d, 8'h80, 1'b1);
        drain();

        // Signed extremes.
        for (int i = 0; i < N; i++) d[i*DW +: DW] = 8'h80;
        hd = '0; hd[7*DWO +: DWO] = 16'hFC00;
        h_arm = 1'b1; h_data = hd;
        send(d, 8'h80, 1'b1);
        for (int i = 0; i < N; i++) d[i*DW +: DW] = 8'h7F;
        hd = '0; hd[7*DWO +: DWO] = 16'h03F8;
        h_arm = 1'b1; h_data = hd;
        send(d, 8'h80, 1'b0);
        drain();

        // Backpressure: stream with the sink blocked, then release.
        cnt = 0;
        rand_beat(d, l, s);
        for (int t = 0; t < 8; t++) begin
            step(1'b1, d, l, s, 1'b0, acc);
            if (acc) begin cnt++; rand_beat(d, l, s); end
        end
        check_eq("bp_beats_held", cnt, L + 2);
        check_eq("bp_in_ready", in_ready, 0);
        while (cnt < 8) begin
            step(1'b1, d, l, s, 1'b1, acc);
            if (acc) begin cnt++; rand_beat(d, l, s); end
        end
        drain();

        // Reset with a pending carry and beats in flight.
        rand_beat(d, l, s);
        send(d, 8'h00, 1'b1);
        drain();
        for (int b = 0; b < 3; b++) begin
            rand_beat(d, l, s);
            send(d, 8'h00, 1'b0);
        end
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0;
        #1;
        check_eq("arst_out_valid", out_valid, 0);
        check_eq("arst_carry_pending", carry_pending, 0);
        exp_q.delete();
        m_pend = 1'b0; m_carry = '0; stall_prev = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        d = '0; d[0 +: DW] = 8'd5;
        hd = '0; hd[0 +: DWO] = 16'd5;
        h_arm = 1'b1; h_data = hd;
        send(d, 8'h01, 1'b0);
        drain();

        // Random traffic with random sink stalls.
        iv = 1'b0;
        rand_beat(d, l, s);
        for (int c = 0; c < 1500; c++) begin
            if (!iv) iv = ($urandom_range(0, 3) != 0);
            step(iv, d, l, s, ($urandom_range(0, 9) < 7), acc);
            if (acc) begin
                rand_beat(d, l, s);
                iv = ($urandom_range(0, 3) != 0);
            end
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
